imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 190 +++++++++++++++++++
 tb/tb_imem_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : This block writes the instruction memory. It takes a byte stream
//            over a valid/ready handshake and assembles little-endian 32-bit
//            words. Each word goes to the instruction-memory write port. The
//            pipeline core stays in reset until a complete, valid image has
//            been loaded.
//            Frame format: N[7:0], N[15:8], then N*4 payload bytes, then one
//            checksum byte when the checksum build is selected.
// Options  : IMEM_LOADER_CHECKSUM_EN -- when defined, the frame ends with an
//            XOR checksum of the payload bytes, which is verified in state CHK.
// Ports    : clk        system clock, rising edge
//            rst        asynchronous active-high reset
//            in_valid   byte-stream valid
//            in_data    byte-stream data
//            in_ready   a byte can be accepted this cycle
//            start      re-arm pulse, honoured in DONE or ERR only
//            imem_we    instruction-memory write enable (one-cycle pulse)
//            imem_addr  word address of the write
//            imem_wdata word being written
//            core_rst   active-high reset to the pipeline core
//            done       load completed successfully
//            error      load failed
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    CNT_LO = 3'd0,
    CNT_HI = 3'd1,
    DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK    = 3'd3,
`endif
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [1:0]      lane;      // byte position inside the word being built
  logic [ADDR_W:0] word_cnt;  // words already handed to the write port
  logic [15:0]     n;         // word count taken from the frame header
  logic [23:0]     word_lo;   // lanes 0..2 of the word being built

  logic            accept;
  logic            last_lane;
  logic            last_word;
  logic [15:0]     n_full;
  logic            n_bad;
  logic            rearm;
  logic            done_next;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
  logic            chk_ok;
  assign chk_ok = (in_data == csum);
`endif

  assign accept    = in_valid && in_ready;
  assign last_lane = (lane == 2'd3);
  assign last_word = ((16'(word_cnt) + 16'd1) == n);
  assign n_full    = {in_data, n[7:0]};
  assign n_bad     = (n_full == 16'd0) || ({1'b0, n_full} > MAX_N);
  assign rearm     = ((state == DONE) || (state == ERR)) && start;

  // The last lane leaves DATA on the same cycle that the final write is
  // registered. The write pulse and the exit from DATA therefore appear
  // together. In the plain build, done is held back one more cycle (see
  // done_next) so that it follows the last write pulse.
  always_comb begin
    next_state = state;
    case (state)
      CNT_LO: if (accept) next_state = CNT_HI;
      CNT_HI: if (accept) next_state = n_bad ? ERR : DATA;
      DATA: begin
        if (accept && last_lane && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = CHK;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:    if (accept) next_state = chk_ok ? DONE : ERR;
`endif
      DONE:   if (start) next_state = CNT_LO;
      ERR:    if (start) next_state = CNT_LO;
      default: next_state = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CNT_LO;
    else     state <= next_state;
  end

  // A DATA->DONE step coincides with the final write, so done is set one
  // cycle later. A CHK->DONE step sets done immediately.
  assign done_next = (next_state == DONE) && (state != DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      core_rst <= 1'b1;
    end else begin
      in_ready <= (next_state != DONE) && (next_state != ERR);
      done     <= done_next;
      error    <= (next_state == ERR);
      core_rst <= !done_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane       <= 2'd0;
      word_cnt   <= '0;
      n          <= 16'd0;
      word_lo    <= 24'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (rearm) begin
        lane     <= 2'd0;
        word_cnt <= '0;
        n        <= 16'd0;
        word_lo  <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= 8'd0;
`endif
      end else if (accept) begin
        case (state)
          CNT_LO: n[7:0]  <= in_data;
          CNT_HI: n[15:8] <= in_data;
          DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ in_data;
`endif
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_lo[7:0]   <= in_data;
              2'd1: word_lo[15:8]  <= in_data;
              2'd2: word_lo[23:16] <= in_data;
              default: begin
                // Lane 3 goes straight into the write register. This keeps
                // the next lane 0 free to arrive on the following cycle.
                imem_we    <= 1'b1;
                imem_addr  <= word_cnt[ADDR_W-1:0];
                imem_wdata <= {in_data, word_lo};
                word_cnt   <= word_cnt + (ADDR_W+1)'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. It sends directed frames
//            and randomized frames. Writes and final status are compared
//            against a frame-level model. Builds with or without
//            IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit stuck       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write seen, plus the cycles of the last accepted byte,
  // the last write, and the rising edges of done and error.
  logic [ADDR_W+31:0] wq[$];
  int   last_we_cyc   = 0;
  int   last_acc_cyc  = 0;
  int   done_rise_cyc = 0;
  int   err_rise_cyc  = 0;
  logic prev_done     = 1'b0;
  logic prev_err      = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      wq.push_back({imem_addr, imem_wdata});
      last_we_cyc <= cyc;
    end
    if (in_valid && in_ready) last_acc_cyc <= cyc;
    if (done && !prev_done)   done_rise_cyc <= cyc;
    if (error && !prev_err)   err_rise_cyc <= cyc;
    prev_done <= done;
    prev_err  <= error;
  end

  logic [31:0] fw[$];  // payload words of the next frame

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. Returns at posedge+1 after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (stuck) return;
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      stuck = 1'b1;
      check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // Frame-level model: if N is legal, words 0..N-1 of fw are written in
  // order. The result is success unless N is illegal or the checksum byte
  // is wrong.
  task automatic run_frame(input string tag, input logic [15:0] n,
                           input int gap_lo, input int gap_hi, input logic [7:0] chk_flip);
    logic [7:0] bytes[$];
    logic [7:0] x;
    bit         n_ok;
    bit         exp_ok;
    int         base;
    int         t;
    int         nw;
    base   = wq.size();
    stuck  = 1'b0;
    n_ok   = (n != 16'd0) && (int'(n) <= MAX_WORDS);
    exp_ok = n_ok;
    x      = 8'd0;
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    if (n_ok) begin
      for (int w = 0; w < int'(n); w++) begin
        for (int k = 0; k < 4; k++) begin
          bytes.push_back(fw[w][8*k +: 8]);
          x = x ^ fw[w][8*k +: 8];
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      bytes.push_back(x ^ chk_flip);
      exp_ok = (chk_flip == 8'd0);
`endif
    end
    foreach (bytes[i]) send_byte(bytes[i], int'($urandom_range(gap_hi, gap_lo)));
    in_valid = 1'b0;
    t = 0;
    while (!done && !error && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    @(negedge clk); #1;
    nw = n_ok ? int'(n) : 0;
    check({tag, "_nwrites"}, 64'(wq.size() - base), 64'(nw));
    for (int w = 0; w < nw && base + w < wq.size(); w++) begin
      logic [ADDR_W-1:0] a;
      a = w[ADDR_W-1:0];
      check({tag, "_write"}, 64'(wq[base+w]), 64'({a, fw[w]}));
    end
    check({tag, "_done"},     64'(done),     64'(exp_ok));
    check({tag, "_error"},    64'(error),    64'(!exp_ok));
    check({tag, "_core_rst"}, 64'(core_rst), 64'(!exp_ok));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    if (exp_ok) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      check({tag, "_done_time"}, 64'(done_rise_cyc), 64'(last_acc_cyc + 1));
`else
      check({tag, "_done_time"}, 64'(done_rise_cyc), 64'(last_we_cyc + 1));
`endif
    end else begin
      check({tag, "_err_time"}, 64'(err_rise_cyc), 64'(last_acc_cyc + 1));
    end
    @(posedge clk); #1;
  endtask

  task automatic rearm(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_rearm_done"},     64'(done),     64'(0));
    check({tag, "_rearm_error"},    64'(error),    64'(0));
    check({tag, "_rearm_core_rst"}, 64'(core_rst), 64'(1));
    check({tag, "_rearm_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   64'(in_ready),   64'(1));
    check({tag, "_imem_we"},    64'(imem_we),    64'(0));
    check({tag, "_imem_addr"},  64'(imem_addr),  64'(0));
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'(0));
    check({tag, "_core_rst"},   64'(core_rst),   64'(1));
    check({tag, "_done"},       64'(done),       64'(0));
    check({tag, "_error"},      64'(error),      64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] n;
    logic [7:0]  flip;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    start    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word program streamed continuously
    fw = '{32'h0000_0013, 32'h0010_0093};
    run_frame("s1", 16'd2, 0, 0, 8'd0);
    rearm("s1");

    // Illegal word counts
    run_frame("s2_n0", 16'd0, 0, 0, 8'd0);
    rearm("s2_n0");
    run_frame("s2_nmax1", 16'h0401, 0, 0, 8'd0);
    rearm("s2_nmax1");

    // Same program with three idle cycles after every byte
    fw = '{32'h0000_0013, 32'h0010_0093};
    run_frame("s3", 16'd2, 3, 3, 8'd0);
    rearm("s3");

    // Reset in the middle of word 1, then a clean reload
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("s4_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame("s4", 16'd2, 0, 0, 8'd0);

    // Re-arm from DONE, then a single-word image
    rearm("s5");
    fw = '{32'hDEAD_BEEF};
    run_frame("s5", 16'd1, 0, 0, 8'd0);
    rearm("s5b");

    // Wrong trailing byte (0x23 instead of 0x22) when checksums are in use
    run_frame("s6_bad", 16'd1, 0, 0, 8'h01);
    rearm("s6");

    // Largest legal image
    fw.delete();
    for (int w = 0; w < MAX_WORDS; w++) fw.push_back($urandom());
    run_frame("max", 16'(MAX_WORDS), 0, 0, 8'd0);
    rearm("max");

    // Randomized legal frames with random stalls and checksum corruption
    for (int r = 0; r < 8; r++) begin
      n = 16'($urandom_range(8, 1));
      fw.delete();
      for (int w = 0; w < int'(n); w++) fw.push_back($urandom());
      flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
      run_frame($sformatf("rnd%0d", r), n, 0, 2, flip);
      rearm($sformatf("rnd%0d", r));
    end

    // Randomized illegal word counts
    for (int r = 0; r < 3; r++) begin
      n = 16'($urandom_range(65535, MAX_WORDS + 1));
      run_frame($sformatf("rnd_bad%0d", r), n, 0, 1, 8'd0);
      rearm($sformatf("rnd_bad%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
